// File: rtl/pc_sequencer_pkg.sv
// Shared codes for the PC sequencer: control-flow op classes, FSM states, trap causes.
package pc_sequencer_pkg;

    localparam logic [2:0] OP_SEQ    = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_TRAP     = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_CALL_OVF  = 2'd1;
    localparam logic [1:0] CAUSE_RET_UNDF  = 2'd2;
    localparam logic [1:0] CAUSE_STACK_OVF = 2'd3;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer driving a return-address stack (push on CALL, pop on RET).
// Latency: 1 cycle per op, RET takes 2 (pop, then PC load from pop_data).
// Backpressure: stall freezes RUN with no strobes; busy holds op during RET_WAIT.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W     = 12,
    parameter int DEPTH    = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      op,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] target,
    input  logic            stall,
    input  logic [PC_W-1:0] pop_data,
    input  logic            overflow,
    output logic [PC_W-1:0] pc,
    output logic            push_sig,
    output logic            pop_sig,
    output logic [PC_W-1:0] push_data,
    output logic            busy,
    output logic            halted,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d, pc_inc;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [1:0]          cause_q, cause_d;
    logic                busy_q, halted_q, trap_q;

    always_comb begin
        pc_inc    = pc_q + 1'b1;
        pc_d      = pc_q;
        depth_d   = depth_q;
        state_d   = state_q;
        cause_d   = cause_q;
        push_sig  = 1'b0;
        pop_sig   = 1'b0;
        push_data = pc_inc;

        // A stack overflow flag means the stack and our depth count disagree; stop before any strobe.
        if (overflow && state_q != ST_TRAP) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_STACK_OVF;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        case (op)
                            OP_JUMP:   pc_d = target;
                            OP_BRANCH: pc_d = branch_taken ? target : pc_inc;
                            OP_CALL: begin
                                if (depth_q == DEPTH_MAX) begin
                                    state_d = ST_TRAP;
                                    cause_d = CAUSE_CALL_OVF;
                                end else begin
                                    push_sig = 1'b1;
                                    pc_d     = target;
                                    depth_d  = depth_q + 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (depth_q == '0) begin
                                    state_d = ST_TRAP;
                                    cause_d = CAUSE_RET_UNDF;
                                end else begin
                                    pop_sig = 1'b1;
                                    depth_d = depth_q - 1'b1;
                                    state_d = ST_RET_WAIT;
                                end
                            end
                            OP_HALT:   state_d = ST_HALTED;
                            default:   pc_d = pc_inc;
                        endcase
                    end
                end
                // The pop is already committed, so stall cannot hold this state.
                ST_RET_WAIT: begin
                    pc_d    = pop_data;
                    state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= PC_W'(RESET_PC);
            depth_q  <= '0;
            cause_q  <= CAUSE_NONE;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            cause_q  <= cause_d;
            busy_q   <= (state_d == ST_RET_WAIT);
            halted_q <= (state_d == ST_HALTED);
            trap_q   <= (state_d == ST_TRAP);
        end
    end

    assign pc         = pc_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer paired with a behavioural 8-entry return-address stack.
module tb_pc_sequencer;

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BRA = 3'd2, CALL = 3'd3, RET = 3'd4, HALT = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic        branch_taken;
    logic [11:0] target;
    logic        stall;
    logic [11:0] pop_data;
    logic        overflow;
    logic [11:0] pc;
    logic        push_sig, pop_sig;
    logic [11:0] push_data;
    logic        busy, halted, trap;
    logic [1:0]  trap_cause;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(12), .DEPTH(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .op(op), .branch_taken(branch_taken), .target(target),
        .stall(stall), .pop_data(pop_data), .overflow(overflow), .pc(pc),
        .push_sig(push_sig), .pop_sig(pop_sig), .push_data(push_data),
        .busy(busy), .halted(halted), .trap(trap), .trap_cause(trap_cause)
    );

    // Stack model; its pointer is cleared with rst to keep successive scenarios independent.
    logic [11:0] stk_mem [8];
    int          stk_sp;
    logic        stk_ovf;
    logic        ovf_force;

    assign overflow = stk_ovf | ovf_force;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_sp  <= 0;
            stk_ovf <= 1'b0;
        end else if (push_sig) begin
            if (stk_sp < 8) begin
                stk_mem[stk_sp] <= push_data;
                stk_sp          <= stk_sp + 1;
            end else begin
                stk_ovf <= 1'b1;
            end
        end else if (pop_sig && stk_sp > 0) begin
            pop_data <= stk_mem[stk_sp-1];
            stk_sp   <= stk_sp - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [11:0] t, input logic tk, input logic st);
        op = o; target = t; branch_taken = tk; stall = st;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(SEQ, 12'h000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic goto_pc(input logic [11:0] a);
        drive(JMP, a, 1'b0, 1'b0);
        tick();
    endtask

    task automatic do_call(input logic [11:0] t, input logic [11:0] ret_addr, input string tag);
        drive(CALL, t, 1'b0, 1'b0);
        check_eq({tag, "_push"}, {31'b0, push_sig}, 1);
        check_eq({tag, "_pdata"}, {20'b0, push_data}, {20'b0, ret_addr});
        tick();
        check_eq({tag, "_pc"}, {20'b0, pc}, {20'b0, t});
    endtask

    task automatic do_ret(input logic [11:0] exp_pc, input string tag);
        drive(RET, 12'h000, 1'b0, 1'b0);
        tick();
        check_eq({tag, "_busy"}, {31'b0, busy}, 1);
        tick();
        check_eq({tag, "_pc"}, {20'b0, pc}, {20'b0, exp_pc});
        drive(SEQ, 12'h000, 1'b0, 1'b0);
    endtask

    initial begin
        ovf_force = 1'b0;
        do_reset();

        // Reset values
        check_eq("rst_pc", {20'b0, pc}, 0);
        check_eq("rst_flags", {29'b0, busy, halted, trap}, 0);
        check_eq("rst_cause", {30'b0, trap_cause}, 0);

        // 1: sequential stepping and wrap
        for (int i = 1; i <= 3; i++) begin
            check_eq("seq_strobes", {30'b0, push_sig, pop_sig}, 0);
            tick();
            check_eq("seq_pc", {20'b0, pc}, i);
        end
        goto_pc(12'hFFF);
        drive(SEQ, 12'h000, 1'b0, 1'b0);
        tick();
        check_eq("seq_wrap", {20'b0, pc}, 0);

        // 2: single CALL / RET
        goto_pc(12'h010);
        do_call(12'h200, 12'h011, "call1");
        drive(RET, 12'h000, 1'b0, 1'b0);
        check_eq("ret1_pop", {31'b0, pop_sig}, 1);
        check_eq("ret1_nopush", {31'b0, push_sig}, 0);
        tick();
        check_eq("ret1_busy", {31'b0, busy}, 1);
        check_eq("ret1_pc_hold", {20'b0, pc}, 12'h200);
        check_eq("ret1_wait_nopop", {31'b0, pop_sig}, 0);
        tick();
        check_eq("ret1_pc", {20'b0, pc}, 12'h011);
        check_eq("ret1_busy_clr", {31'b0, busy}, 0);

        // 3: nested calls return in LIFO order
        goto_pc(12'h000);
        do_call(12'h100, 12'h001, "nest1");
        goto_pc(12'h101);
        do_call(12'h200, 12'h102, "nest2");
        goto_pc(12'h202);
        do_call(12'h300, 12'h203, "nest3");
        do_ret(12'h203, "nret3");
        do_ret(12'h102, "nret2");
        do_ret(12'h001, "nret1");

        // 4: call overflow, then return underflow
        for (int i = 0; i < 8; i++) begin
            drive(CALL, 12'h400 + 12'(i), 1'b0, 1'b0);
            tick();
        end
        check_eq("fill_pc", {20'b0, pc}, 12'h407);
        drive(CALL, 12'h7FF, 1'b0, 1'b0);
        check_eq("ovf_nopush", {31'b0, push_sig}, 0);
        tick();
        check_eq("ovf_trap", {31'b0, trap}, 1);
        check_eq("ovf_cause", {30'b0, trap_cause}, 1);
        drive(SEQ, 12'h000, 1'b0, 1'b0);
        tick();
        check_eq("ovf_pc_frozen", {20'b0, pc}, 12'h407);
        do_reset();
        drive(RET, 12'h000, 1'b0, 1'b0);
        check_eq("undf_nopop", {31'b0, pop_sig}, 0);
        tick();
        check_eq("undf_trap", {31'b0, trap}, 1);
        check_eq("undf_cause", {30'b0, trap_cause}, 2);

        // 5: stalled CALL leaves depth at 0, so a later RET must underflow
        do_reset();
        goto_pc(12'h050);
        drive(CALL, 12'h600, 1'b0, 1'b1);
        check_eq("stall_nopush", {31'b0, push_sig}, 0);
        tick();
        check_eq("stall_pc", {20'b0, pc}, 12'h050);
        drive(RET, 12'h000, 1'b0, 1'b0);
        tick();
        check_eq("stall_depth", {30'b0, trap_cause}, 2);

        do_reset();
        goto_pc(12'h020);
        do_call(12'h300, 12'h021, "scall");
        drive(RET, 12'h000, 1'b0, 1'b0);
        tick();
        drive(RET, 12'h000, 1'b0, 1'b1);
        tick();
        check_eq("stall_retwait_pc", {20'b0, pc}, 12'h021);
        goto_pc(12'h040);
        drive(BRA, 12'h080, 1'b1, 1'b0);
        tick();
        check_eq("br_taken", {20'b0, pc}, 12'h080);
        goto_pc(12'h040);
        drive(BRA, 12'h080, 1'b0, 1'b0);
        tick();
        check_eq("br_not_taken", {20'b0, pc}, 12'h041);
        drive(HALT, 12'h000, 1'b0, 1'b0);
        tick();
        check_eq("halt_flag", {31'b0, halted}, 1);
        drive(JMP, 12'h123, 1'b0, 1'b0);
        tick();
        check_eq("halt_pc_frozen", {20'b0, pc}, 12'h041);

        // 6: async reset in RET_WAIT, then forced stack overflow flag
        do_reset();
        goto_pc(12'h030);
        do_call(12'h500, 12'h031, "rcall");
        drive(RET, 12'h000, 1'b0, 1'b0);
        tick();
        check_eq("rw_busy", {31'b0, busy}, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_pc", {20'b0, pc}, 0);
        check_eq("arst_busy", {31'b0, busy}, 0);
        check_eq("arst_strobes", {30'b0, push_sig, pop_sig}, 0);
        tick();
        rst = 1'b0;
        drive(SEQ, 12'h000, 1'b0, 1'b0);
        ovf_force = 1'b1;
        #1;
        tick();
        check_eq("sovf_trap", {31'b0, trap}, 1);
        check_eq("sovf_cause", {30'b0, trap_cause}, 3);
        check_eq("sovf_pc", {20'b0, pc}, 0);
        ovf_force = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
